// File: rtl/adc_parallel_model.sv
// Cycle-based model of an 8-channel simultaneous-sampling SAR ADC with a 16-bit parallel bus.
// Optional macro CFG_READBACK_EN: CONFIG[30] appends the CONFIG register as read words 8 and 9.
module adc_parallel_model #(
    parameter int unsigned CONV_CYCLES = 19,
    parameter logic [31:0] CFG_RESET   = 32'h0000_03FF
) (
    input  logic        XCLK,
    input  logic        CS_N,
    input  logic        WR_N,
    input  logic        RD_N,
    input  logic        CONVST_A,
    input  logic        CONVST_B,
    input  logic        CONVST_C,
    input  logic        CONVST_D,
    output logic        BUSY,
    inout  wire  [15:0] DB,
    input  logic        RESET_N
);

    localparam int unsigned DW     = 16;
    localparam int unsigned CW     = 32;
    localparam int unsigned NCH    = 8;
    localparam int unsigned NPAIR  = 4;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned CYC_W  = 8;
    localparam int unsigned PTR_W  = 4;
    localparam int unsigned CH_W   = 4;

    localparam logic [PTR_W-1:0] LAST_WORD    = PTR_W'(7);
    localparam logic [PTR_W-1:0] CFG_HI_WORD  = PTR_W'(8);
    localparam logic [PTR_W-1:0] CFG_LO_WORD  = PTR_W'(9);
    localparam logic [CYC_W-1:0] CONV_LOAD    = CYC_W'(CONV_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    // Input synchroniser stage (q) and previous registered value (p)
    logic             cs_q, cs_p;
    logic             wr_q, wr_p;
    logic             rd_q, rd_p;
    logic [NPAIR-1:0] cv_q, cv_p;

    logic             cs_rise_c;
    logic             wr_fall_c;
    logic             rd_rise_c;
    logic [NPAIR-1:0] cv_rise_c;

    state_t           state, state_nx;
    logic [CYC_W-1:0] cyc, cyc_nx;
    logic             conv_start_c;
    logic             conv_done_c;

    logic [NPAIR-1:0] pair_mask;
    logic [CNT_W-1:0] conv_cnt;
    logic [DW-1:0]    result [NCH];

    logic             wr_phase;
    logic [DW-1:0]    cfg_upper;
    logic [CW-1:0]    cfg_reg;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] last_word_c;
    logic [DW-1:0]    read_word_c;
    logic             read_en_c;

    // Register the strobes and conversion starts once, keep the previous sample for edge detection
    always_ff @(posedge XCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_q <= 1'b1;
            cs_p <= 1'b1;
            wr_q <= 1'b1;
            wr_p <= 1'b1;
            rd_q <= 1'b1;
            rd_p <= 1'b1;
            cv_q <= '0;
            cv_p <= '0;
        end else begin
            cs_q <= CS_N;
            cs_p <= cs_q;
            wr_q <= WR_N;
            wr_p <= wr_q;
            rd_q <= RD_N;
            rd_p <= rd_q;
            cv_q <= {CONVST_D, CONVST_C, CONVST_B, CONVST_A};
            cv_p <= cv_q;
        end
    end

    always_comb begin
        cs_rise_c = cs_q & ~cs_p;
        wr_fall_c = ~wr_q & wr_p & ~cs_q;
        rd_rise_c = rd_q & ~rd_p & ~cs_q;
        cv_rise_c = cv_q & ~cv_p;
    end

    // Conversion sequencer: state register
    always_ff @(posedge XCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            cyc   <= '0;
        end else begin
            state <= state_nx;
            cyc   <= cyc_nx;
        end
    end

    // Conversion sequencer: next state, cycle countdown and start/done pulses
    always_comb begin
        state_nx     = state;
        cyc_nx       = cyc;
        conv_start_c = 1'b0;
        conv_done_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|cv_rise_c) begin
                    state_nx     = ST_CONV;
                    cyc_nx       = CONV_LOAD;
                    conv_start_c = 1'b1;
                end
            end
            ST_CONV: begin
                if (cyc == '0) begin
                    state_nx    = ST_IDLE;
                    conv_done_c = 1'b1;
                end else begin
                    cyc_nx = cyc - CYC_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign BUSY = (state == ST_CONV);

    // Pair mask captures every pair that started in the same cycle as the conversion
    always_ff @(posedge XCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pair_mask <= '0;
        end else if (conv_start_c) begin
            pair_mask <= cv_rise_c;
        end
    end

    // Result bank: masked pairs take {channel, count} when BUSY falls
    always_ff @(posedge XCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            conv_cnt <= '0;
            for (int k = 0; k < NCH; k++) begin
                result[k] <= '0;
            end
        end else if (conv_done_c) begin
            conv_cnt <= conv_cnt + CNT_W'(1);
            for (int p = 0; p < NPAIR; p++) begin
                if (pair_mask[p]) begin
                    result[2*p]   <= {CH_W'(2*p), conv_cnt};
                    result[2*p+1] <= {CH_W'(2*p+1), conv_cnt};
                end
            end
        end
    end

    // Two-word CONFIG write; a deselect between the words discards the upper half
    always_ff @(posedge XCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_phase  <= 1'b0;
            cfg_upper <= '0;
            cfg_reg   <= CFG_RESET;
        end else if (wr_fall_c) begin
            if (!wr_phase) begin
                if (DB[DW-1]) begin
                    cfg_upper <= DB;
                    wr_phase  <= 1'b1;
                end
            end else begin
                cfg_reg  <= {cfg_upper, DB};
                wr_phase <= 1'b0;
            end
        end else if (cs_rise_c && wr_phase) begin
            wr_phase <= 1'b0;
        end
    end

`ifdef CFG_READBACK_EN
    assign last_word_c = cfg_reg[30] ? CFG_LO_WORD : LAST_WORD;
`else
    assign last_word_c = LAST_WORD;
`endif

    // Read pointer: advances on RD_N release, restarts on deselect or fresh results
    always_ff @(posedge XCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr <= '0;
        end else if (cs_rise_c || conv_done_c) begin
            ptr <= '0;
        end else if (rd_rise_c) begin
            if (ptr == last_word_c) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

    always_comb begin
        read_word_c = '0;
        if (ptr <= LAST_WORD) begin
            read_word_c = result[ptr[2:0]];
        end else if (ptr == CFG_HI_WORD) begin
            read_word_c = cfg_reg[CW-1:DW];
        end else if (ptr == CFG_LO_WORD) begin
            read_word_c = cfg_reg[DW-1:0];
        end
    end

    assign read_en_c = ~CS_N & ~RD_N & WR_N;
    assign DB        = read_en_c ? read_word_c : {DW{1'bz}};

endmodule

// File: tb/tb_adc_parallel_model.sv
// Directed bench for adc_parallel_model: reset, conversions, reads, CONFIG writes, readback.
// Compile with +define+CFG_READBACK_EN to exercise the CONFIG readback words.
module tb_adc_parallel_model;

    logic        XCLK;
    logic        RESET_N;
    logic        CS_N;
    logic        WR_N;
    logic        RD_N;
    logic        CONVST_A;
    logic        CONVST_B;
    logic        CONVST_C;
    logic        CONVST_D;
    logic        BUSY;
    wire  [15:0] DB;

    logic        db_oe;
    logic [15:0] db_drv;
    logic [15:0] rd [16];
    logic [15:0] exp_w [16];

    int n_cmp;
    int n_err;

    assign DB = db_oe ? db_drv : 16'hzzzz;

    adc_parallel_model #(
        .CONV_CYCLES(19),
        .CFG_RESET  (32'h0000_03FF)
    ) dut (
        .XCLK    (XCLK),
        .CS_N    (CS_N),
        .WR_N    (WR_N),
        .RD_N    (RD_N),
        .CONVST_A(CONVST_A),
        .CONVST_B(CONVST_B),
        .CONVST_C(CONVST_C),
        .CONVST_D(CONVST_D),
        .BUSY    (BUSY),
        .DB      (DB),
        .RESET_N (RESET_N)
    );

    initial XCLK = 1'b0;
    always #5 XCLK = ~XCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge XCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_convst(input logic [3:0] m);
        {CONVST_D, CONVST_C, CONVST_B, CONVST_A} = m;
    endtask

    // Read n sequential words in one chip-select window
    task automatic read_words(input int n);
        CS_N = 1'b0;
        tick(3);
        for (int i = 0; i < n; i++) begin
            RD_N = 1'b0;
            tick(2);
            rd[i] = DB;
            RD_N = 1'b1;
            tick(3);
        end
        CS_N = 1'b1;
        tick(3);
    endtask

    task automatic check_words(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d", tag, i), {16'h0, rd[i]}, {16'h0, exp_w[i]});
        end
    endtask

    task automatic wr_word(input logic [15:0] v);
        db_drv = v;
        db_oe  = 1'b1;
        WR_N   = 1'b0;
        tick(3);
        WR_N   = 1'b1;
        tick(3);
        db_oe  = 1'b0;
    endtask

    // Raise the selected CONVST pins and confirm BUSY rises on the second edge
    task automatic conv_start(input string tag, input logic [3:0] m);
        set_convst(m);
        tick(1);
        chk({tag, "_busy_pre"}, {31'h0, BUSY}, 32'h0);
        tick(1);
        chk({tag, "_busy_rise"}, {31'h0, BUSY}, 32'h1);
        set_convst(4'b0000);
    endtask

    // Count remaining BUSY-high samples; already is how many were seen so far
    task automatic conv_wait(input string tag, input int already);
        int n;
        n = already;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (!BUSY) break;
            n++;
        end
        chk({tag, "_busy_len"}, 32'(n), 32'd19);
        tick(2);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        db_oe   = 1'b0;
        db_drv  = 16'h0;
        RESET_N = 1'b0;
        CS_N    = 1'b1;
        WR_N    = 1'b1;
        RD_N    = 1'b1;
        set_convst(4'b0000);
        tick(3);
        RESET_N = 1'b1;
        tick(3);

        // Reset state
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        chk("rst_config", dut.cfg_reg, 32'h0000_03FF);
        read_words(8);
        for (int i = 0; i < 8; i++) exp_w[i] = 16'h0000;
        check_words("rst", 8);

        // Reset in the middle of a conversion
        conv_start("rstconv", 4'b1111);
        tick(4);
        RESET_N = 1'b0;
        #1;
        chk("rstconv_busy_drop", {31'h0, BUSY}, 32'h0);
        tick(2);
        RESET_N = 1'b1;
        tick(30);
        chk("rstconv_busy_stays_low", {31'h0, BUSY}, 32'h0);
        chk("rstconv_count", {20'h0, dut.conv_cnt}, 32'h0);
        read_words(8);
        check_words("rstconv", 8);

        // All pairs, count 0; ninth read wraps back to word 0
        conv_start("all0", 4'b1111);
        conv_wait("all0", 1);
        read_words(9);
        exp_w[0] = 16'h0000; exp_w[1] = 16'h1000; exp_w[2] = 16'h2000; exp_w[3] = 16'h3000;
        exp_w[4] = 16'h4000; exp_w[5] = 16'h5000; exp_w[6] = 16'h6000; exp_w[7] = 16'h7000;
        exp_w[8] = 16'h0000;
        check_words("all0", 9);

        // Pair B only, count 1
        conv_start("pairb", 4'b0010);
        conv_wait("pairb", 1);
        read_words(8);
        exp_w[2] = 16'h2001; exp_w[3] = 16'h3001;
        check_words("pairb", 8);

        // All pairs again, count 2
        conv_start("all2", 4'b1111);
        conv_wait("all2", 1);
        read_words(8);
        exp_w[0] = 16'h0002; exp_w[1] = 16'h1002; exp_w[2] = 16'h2002; exp_w[3] = 16'h3002;
        exp_w[4] = 16'h4002; exp_w[5] = 16'h5002; exp_w[6] = 16'h6002; exp_w[7] = 16'h7002;
        check_words("all2", 8);

        // Pair A, with a CONVST_D pulse during BUSY that must be ignored, count 3
        conv_start("ign", 4'b0001);
        tick(3);
        CONVST_D = 1'b1;
        tick(3);
        CONVST_D = 1'b0;
        conv_wait("ign", 7);
        chk("ign_no_restart", {31'h0, BUSY}, 32'h0);
        read_words(8);
        exp_w[0] = 16'h0003; exp_w[1] = 16'h1003;
        check_words("ign", 8);

        // Two-word CONFIG write
        CS_N = 1'b0;
        tick(3);
        wr_word(16'h8054);
        chk("wr_half_config", dut.cfg_reg, 32'h0000_03FF);
        wr_word(16'h03FF);
        CS_N = 1'b1;
        tick(3);
        chk("wr_full_config", dut.cfg_reg, 32'h8054_03FF);

        // Lone word without bit 15 is ignored
        CS_N = 1'b0;
        tick(3);
        wr_word(16'h0054);
        CS_N = 1'b1;
        tick(3);
        chk("wr_ignored_config", dut.cfg_reg, 32'h8054_03FF);

        // Deselect between the words aborts; the later low word alone is ignored
        CS_N = 1'b0;
        tick(3);
        wr_word(16'h8123);
        CS_N = 1'b1;
        tick(3);
        CS_N = 1'b0;
        tick(3);
        wr_word(16'h0456);
        CS_N = 1'b1;
        tick(3);
        chk("wr_abort_config", dut.cfg_reg, 32'h8054_03FF);

        // Set CONFIG[30] and read past word 7
        CS_N = 1'b0;
        tick(3);
        wr_word(16'hC000);
        wr_word(16'h0000);
        CS_N = 1'b1;
        tick(3);
        chk("rb_config", dut.cfg_reg, 32'hC000_0000);
        read_words(11);
`ifdef CFG_READBACK_EN
        exp_w[8]  = 16'hC000;
        exp_w[9]  = 16'h0000;
        exp_w[10] = exp_w[0];
`else
        exp_w[8]  = exp_w[0];
        exp_w[9]  = exp_w[1];
        exp_w[10] = exp_w[2];
`endif
        check_words("rb", 11);
        chk("end_busy", {31'h0, BUSY}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_parallel_model.md
# adc_parallel_model

Cycle-based model of an 8-channel, 4-pair simultaneous-sampling SAR ADC with a 16-bit parallel bus, clocked by XCLK. It accepts two-word configuration writes, runs conversions started by the CONVST_A..D pins and signals them on BUSY. Results are returned as sequential 16-bit reads on the tri-state DB bus. Used as the device model when verifying the ADC driver firmware/RTL.

## Interface
Parameters:
- CONV_CYCLES, 19: XCLK cycles BUSY stays high per conversion (valid range 2..255).
- CFG_RESET, 32'h0000_03FF: reset value of the 32-bit CONFIG register.

Ports (declaration order: XCLK, CS_N, WR_N, RD_N, CONVST_A, CONVST_B, CONVST_C, CONVST_D, BUSY, DB, RESET_N):
- XCLK, input, 1: the single clock; all state changes on its rising edge.
- RESET_N, input, 1: reset is asynchronous and active-low.
- CS_N, input, 1: chip select, active low; gates reads and writes.
- WR_N, input, 1: write strobe, active low.
- RD_N, input, 1: read strobe, active low.
- CONVST_A..CONVST_D, input, 1 each: conversion start for channel pairs A..D, rising-edge triggered.
- BUSY, output, 1: high while a conversion is in progress.
- DB, inout, 16: data bus; driven only during reads, otherwise high-Z.

## Operation
- Reset: BUSY=0, CONFIG=CFG_RESET, all 8 results=0, conversion counter=0, read pointer=0, write phase=0, DB high-Z.
- Input sampling:
  - CS_N, WR_N, RD_N and CONVST_x are each registered once on XCLK.
  - Events are the falling or rising edges between the registered value and the previous registered value.
- Write (two words):
  - A WR_N falling event is accepted only with CS_N low; DB is sampled at that event.
  - Phase 0 with DB[15]=1: store the word as the CONFIG upper half and go to phase 1.
  - Phase 0 with DB[15]=0: ignore the word.
  - Phase 1: commit {upper, DB} to CONFIG and return to phase 0.
  - A CS_N rising event in phase 1 aborts the write: CONFIG is unchanged and the phase returns to 0.
- Conversion:
  - Any CONVST_x rising event while BUSY=0 starts a conversion: BUSY rises and the pair mask latches all CONVST_x rising events seen in that same cycle.
  - CONVST events while BUSY=1 are ignored.
  - BUSY stays high CONV_CYCLES cycles.
  - On the cycle BUSY falls:
    - Each masked pair's two channels load result[k] = {k[3:0], count[11:0]}, with k = 0..7 in order A0,A1,B0,B1,C0,C1,D0,D1.
    - Unmasked pairs keep their old results.
    - count increments (12-bit wrap).
    - The read pointer clears to 0.
- Read:
  - DB is driven combinationally with result[ptr] while CS_N=0, RD_N=0 and WR_N=1; otherwise high-Z.
  - A RD_N rising event with CS_N low advances ptr. After 7 it wraps to 0, unless readback is enabled (see Configuration).
  - A CS_N rising event clears ptr to 0.
  - Reads during BUSY return the previous results.

## Timing
- An input change takes effect at most 2 XCLK rising edges later.
- Strobe low/high widths must each be ≥2 XCLK periods.
- BUSY rises 2 edges after the CONVST rising edge and is high exactly CONV_CYCLES cycles.
- After RD_N rises, the next word is on DB within 2 XCLK periods.
- RESET_N low mid-conversion: BUSY drops immediately and the results are not updated.

## Configuration
- Macro CFG_READBACK_EN.
- Defined, with CONFIG[30]=1: read words 8 and 9 return CONFIG[31:16] then CONFIG[15:0], then ptr wraps to 0.
- Defined, with CONFIG[30]=0: the wrap is after word 7.
- Undefined: CONFIG[30] is ignored and the wrap is always after word 7.

## Test plan
- Reset, then read with CS_N low: DB=16'h0000 for all 8 words, BUSY=0, CONFIG=32'h0000_03FF.
- All four CONVST pulsed high: BUSY high 19 cycles; 8 reads return 16'h0000,16'h1000,…,16'h7000; a second conversion returns 16'h0001,…,16'h7001.
- CONVST_B only, after one full conversion: words 2–3 = 16'h2001/16'h3001; words 0,1,4..7 keep count 0.
- Write 16'h8054 then 16'h03FF: CONFIG=32'h8054_03FF. Writing 16'h0054 alone leaves CONFIG unchanged. CS_N rising between the two words aborts the write.
- CONVST pulse while BUSY=1: ignored. RESET_N low during BUSY: BUSY=0 at once, results unchanged.
- With CFG_READBACK_EN defined, write 16'hC000, 16'h0000: reads 8 and 9 return 16'hC000, 16'h0000, then word 0 follows.
